// File: rtl/cache_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter_if
//
// Bundles the two requester ports and the cache-side port of the
// cache_port_arbiter into one interface.
//
// Signals:
//   pN_req / pN_rw / pN_addr / pN_wdata   requester N operands (N = 0, 1)
//   pN_done / pN_rdata / pN_err           requester N completion and result
//   c_req / c_rw / c_addr / c_wdata       request towards the cache
//   c_rdata / c_ready                     response from the cache
//
// Modports:
//   master  arbiter view (drives done/rdata/err and the cache request)
//   slave   environment view (requesters and cache model)
// ---------------------------------------------------------------------------
interface cache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_rw;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_rw;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic              c_req;
    logic              c_rw;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ready;

    modport master (
        input  p0_req, p0_rw, p0_addr, p0_wdata,
        output p0_done, p0_rdata, p0_err,
        input  p1_req, p1_rw, p1_addr, p1_wdata,
        output p1_done, p1_rdata, p1_err,
        output c_req, c_rw, c_addr, c_wdata,
        input  c_rdata, c_ready
    );

    modport slave (
        output p0_req, p0_rw, p0_addr, p0_wdata,
        input  p0_done, p0_rdata, p0_err,
        output p1_req, p1_rw, p1_addr, p1_wdata,
        input  p1_done, p1_rdata, p1_err,
        input  c_req, c_rw, c_addr, c_wdata,
        output c_rdata, c_ready
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares one single-ported cache between port 0 (instruction fetch) and
// port 1 (load/store). Round-robin arbitration, one access outstanding at a
// time. The winner's operands are registered and held on the cache side
// until the cache answers (c_ready) or the timeout expires; the winner then
// gets its read data / error flag and a one-cycle done pulse.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   bus         cache_port_arbiter_if.master (both requesters + cache side)
//   p0_gnt_cnt  grants to port 0, saturating        (CACHE_ARB_STATS_EN only)
//   p1_gnt_cnt  grants to port 1, saturating        (CACHE_ARB_STATS_EN only)
//   stall_cnt   cycles a non-active port requested  (CACHE_ARB_STATS_EN only)
//
// Parameters:
//   ADDR_W, DATA_W  bus widths (must match the interface instance)
//   TIMEOUT_CYC     BUSY cycles before an access is aborted with error;
//                   0 disables the timeout
//
// Build option: define CACHE_ARB_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_port_arbiter_if.master bus
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [15:0]          p0_gnt_cnt,
    output logic [15:0]          p1_gnt_cnt,
    output logic [15:0]          stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int   CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit   TMO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    state_t           state;
    state_t           state_nxt;
    logic             last_gnt;
    logic             gnt_id;
    logic [CNT_W-1:0] tmo_cnt;

    logic             grant;
    logic             grant_id;
    logic             finish_ok;
    logic             finish_tmo;
    logic             finish;

    // Next-state and strobe decode. In IDLE a lone requester wins outright;
    // when both request, the port that did not win last time gets the grant.
    // In BUSY a ready cache always wins over a timeout in the same cycle.
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_id   = 1'b0;
        finish_ok  = 1'b0;
        finish_tmo = 1'b0;
        case (state)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                    if (bus.p0_req && bus.p1_req) begin
                        grant_id = ~last_gnt;
                    end else begin
                        grant_id = bus.p1_req;
                    end
                end
            end
            BUSY: begin
                if (bus.c_ready) begin
                    finish_ok = 1'b1;
                    state_nxt = RESP;
                end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                    finish_tmo = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        finish = finish_ok | finish_tmo;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers. Cache operands are captured at grant time so the
    // requester may change its inputs while the access is in flight. The done
    // pulse is registered on the edge entering RESP and cleared on the next
    // edge, so it is high exactly for the RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt     <= 1'b1;
            gnt_id       <= 1'b0;
            tmo_cnt      <= '0;
            bus.c_req    <= 1'b0;
            bus.c_rw     <= 1'b0;
            bus.c_addr   <= '0;
            bus.c_wdata  <= '0;
            bus.p0_done  <= 1'b0;
            bus.p0_rdata <= '0;
            bus.p0_err   <= 1'b0;
            bus.p1_done  <= 1'b0;
            bus.p1_rdata <= '0;
            bus.p1_err   <= 1'b0;
        end else begin
            if (grant) begin
                gnt_id      <= grant_id;
                tmo_cnt     <= '0;
                bus.c_req   <= 1'b1;
                bus.c_rw    <= grant_id ? bus.p1_rw    : bus.p0_rw;
                bus.c_addr  <= grant_id ? bus.p1_addr  : bus.p0_addr;
                bus.c_wdata <= grant_id ? bus.p1_wdata : bus.p0_wdata;
            end

            if ((state == BUSY) && !bus.c_ready) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (finish) begin
                bus.c_req <= 1'b0;
                last_gnt  <= gnt_id;
                if (gnt_id) begin
                    bus.p1_rdata <= finish_ok ? bus.c_rdata : '0;
                    bus.p1_err   <= finish_tmo;
                end else begin
                    bus.p0_rdata <= finish_ok ? bus.c_rdata : '0;
                    bus.p0_err   <= finish_tmo;
                end
            end

            bus.p0_done <= finish & ~gnt_id;
            bus.p1_done <= finish &  gnt_id;
        end
    end

`ifdef CACHE_ARB_STATS_EN
    logic active_id;
    logic stall_now;

    // The active port is the one being granted while IDLE, otherwise the
    // port owning the current access. Any other port holding req is stalled;
    // at most one port can be stalled per cycle.
    always_comb begin
        active_id = (state == IDLE) ? grant_id : gnt_id;
        stall_now = (bus.p0_req && active_id) || (bus.p1_req && !active_id);
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_gnt_cnt <= '0;
            p1_gnt_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (grant && !grant_id && (p0_gnt_cnt != 16'hFFFF)) begin
                p0_gnt_cnt <= p0_gnt_cnt + 16'd1;
            end
            if (grant && grant_id && (p1_gnt_cnt != 16'hFFFF)) begin
                p1_gnt_cnt <= p1_gnt_cnt + 16'd1;
            end
            if (stall_now && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_port_arbiter
//
// Self-checking bench for cache_port_arbiter (TIMEOUT_CYC = 8). The bench
// plays both requesters and the cache. Define CACHE_ARB_STATS_EN to also
// check the grant counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    cache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef CACHE_ARB_STATS_EN
    logic [15:0] p0_gnt_cnt;
    logic [15:0] p1_gnt_cnt;
    logic [15:0] stall_cnt;
`endif

    cache_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef CACHE_ARB_STATS_EN
        ,
        .p0_gnt_cnt(p0_gnt_cnt),
        .p1_gnt_cnt(p1_gnt_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // One transaction vector: operands for both ports, cache latency/data for
    // the first and second access, and the expected results in service order.
    typedef struct {
        logic        r0;
        logic        r1;
        logic        rw0;
        logic        rw1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] w0;
        logic [31:0] w1;
        int          lat0;
        int          lat1;
        logic [31:0] d0;
        logic [31:0] d1;
        int          first;
        logic [31:0] xd0;
        logic        xe0;
        logic [31:0] xd1;
        logic        xe1;
    } vec_t;

    vec_t vecs[7];

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.p0_req = 1'b0; bus.p0_rw = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_rw = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.c_ready = 1'b0; bus.c_rdata = '0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Serve one access as the cache: check operands every BUSY cycle, raise
    // c_ready after 'lat' BUSY cycles, then check the done pulse and results
    // and drop the winner's req.
    task automatic serveOne(input string tag, input int port, input logic rw,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int lat, input logic [31:0] data,
                            input logic [31:0] xd, input logic xe);
        int n = 0;
        int guard = 0;
        bit got_done = 1'b0;
        while (!got_done && guard < 30) begin
            if (bus.p0_done || bus.p1_done) begin
                got_done = 1'b1;
                checkOutput({tag, " p0_done"}, bus.p0_done, port == 0);
                checkOutput({tag, " p1_done"}, bus.p1_done, port == 1);
                checkOutput({tag, " rdata"}, port ? bus.p1_rdata : bus.p0_rdata, xd);
                checkOutput({tag, " err"}, port ? bus.p1_err : bus.p0_err, xe);
                if (port == 0) bus.p0_req = 1'b0; else bus.p1_req = 1'b0;
                bus.c_ready = 1'b0;
                tick();
            end else if (bus.c_req) begin
                checkOutput({tag, " c_addr"}, bus.c_addr, addr);
                checkOutput({tag, " c_rw"}, bus.c_rw, rw);
                checkOutput({tag, " c_wdata"}, bus.c_wdata, wd);
                bus.c_ready = (n == lat);
                bus.c_rdata = (n == lat) ? data : ~data;
                n++;
                tick();
            end else begin
                bus.c_ready = 1'b0;
                tick();
            end
            guard++;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s done: got none within 30 cycles, expected a done pulse", tag);
        end
    endtask

    // Apply one table vector from an IDLE cycle.
    task automatic applyStimulus(input int idx, input vec_t v);
        int sp;
        int op;
        bus.p0_req = v.r0; bus.p0_rw = v.rw0; bus.p0_addr = v.a0; bus.p0_wdata = v.w0;
        bus.p1_req = v.r1; bus.p1_rw = v.rw1; bus.p1_addr = v.a1; bus.p1_wdata = v.w1;
        sp = v.first;
        op = 1 - sp;
        serveOne($sformatf("vec%0d.a", idx), sp,
                 sp ? v.rw1 : v.rw0, sp ? v.a1 : v.a0, sp ? v.w1 : v.w0,
                 v.lat0, v.d0, v.xd0, v.xe0);
        if (v.r0 && v.r1) begin
            serveOne($sformatf("vec%0d.b", idx), op,
                     op ? v.rw1 : v.rw0, op ? v.a1 : v.a0, op ? v.w1 : v.w0,
                     v.lat1, v.d1, v.xd1, v.xe1);
        end
    endtask

    initial begin
        int n_done;
        int guard;
        // Random-phase model state.
        int          m_busy;
        int          m_resp;
        int          m_last;
        int          m_cnt;
        int          n_busy;
        int          n_resp;
        int          win;
        logic [31:0] m_rdata;
        logic        m_err;
        logic [31:0] op_addr;
        logic [31:0] op_wdata;
        logic        op_rw;
        bit          pend[2];
        logic        q_rw[2];
        logic [31:0] q_addr[2];
        logic [31:0] q_wdata[2];
        logic        rdy;
        logic [31:0] rd;

        // Field order: r0 r1 rw0 rw1 a0 a1 w0 w1 lat0 lat1 d0 d1 first xd0 xe0 xd1 xe1
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h80000004, 32'h80008000, 32'hAABBCCDD, 32'h0,
                    0, 2, 32'h11111111, 32'h22222222, 0, 32'h11111111, 1'b0, 32'h22222222, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h0, 32'h0, 32'h0,
                    0, 0, 32'h12345678, 32'h0, 0, 32'h12345678, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h80001000, 32'h0, 32'h0,
                    3, 0, 32'hCAFEF00D, 32'h0, 1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h80002000, 32'h80003000, 32'h0, 32'h5A5A5A5A,
                    1, 0, 32'h0BADBEEF, 32'h13572468, 0, 32'h0BADBEEF, 1'b0, 32'h13572468, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h80004000, 32'h0, 32'h0,
                    99, 0, 32'hDEADBEEF, 32'h0, 1, 32'h0, 1'b1, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h80005000, 32'h0, 32'h0, 32'h0,
                    7, 0, 32'h76543210, 32'h0, 0, 32'h76543210, 1'b0, 32'h0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h80006000, 32'h80007000, 32'h01020304, 32'h0,
                    0, 99, 32'hA5A5A5A5, 32'h0, 1, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1};

        // Reset values, observed before any clock edge.
        idleInputs();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst c_req", bus.c_req, 1'b0);
        checkOutput("rst c_rw", bus.c_rw, 1'b0);
        checkOutput("rst c_addr", bus.c_addr, 32'h0);
        checkOutput("rst c_wdata", bus.c_wdata, 32'h0);
        checkOutput("rst p0_done", bus.p0_done, 1'b0);
        checkOutput("rst p1_done", bus.p1_done, 1'b0);
        checkOutput("rst p0_rdata", bus.p0_rdata, 32'h0);
        checkOutput("rst p1_rdata", bus.p1_rdata, 32'h0);
        checkOutput("rst p0_err", bus.p0_err, 1'b0);
        checkOutput("rst p1_err", bus.p1_err, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Table vectors, applied back to back from reset.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Latency: req in IDLE cycle t, c_req at t+1, done at t+2.
        bus.p0_req = 1'b1; bus.p0_rw = 1'b0; bus.p0_addr = 32'h80000000;
        checkOutput("lat c_req t", bus.c_req, 1'b0);
        tick();
        checkOutput("lat c_req t+1", bus.c_req, 1'b1);
        checkOutput("lat c_addr", bus.c_addr, 32'h80000000);
        bus.c_ready = 1'b1; bus.c_rdata = 32'h12345678;
        tick();
        checkOutput("lat p0_done t+2", bus.p0_done, 1'b1);
        checkOutput("lat p0_rdata", bus.p0_rdata, 32'h12345678);
        checkOutput("lat p0_err", bus.p0_err, 1'b0);
        bus.p0_req = 1'b0; bus.c_ready = 1'b0;
        tick();
        checkOutput("lat p0_done t+3", bus.p0_done, 1'b0);
        checkOutput("lat c_req t+3", bus.c_req, 1'b0);

        // Fairness: both ports request continuously for six accesses.
        doReset();
        bus.p0_req = 1'b1; bus.p0_addr = 32'h80100000;
        bus.p1_req = 1'b1; bus.p1_addr = 32'h80200000;
        n_done = 0;
        guard  = 0;
        while (n_done < 6 && guard < 60) begin
            if (bus.p0_done || bus.p1_done) begin
                checkOutput($sformatf("fair grant %0d", n_done), bus.p1_done, n_done % 2);
                n_done++;
                if (bus.p0_done) bus.p0_addr = bus.p0_addr + 32'd4;
                else bus.p1_addr = bus.p1_addr + 32'd4;
                if (n_done == 6) begin
                    bus.p0_req = 1'b0;
                    bus.p1_req = 1'b0;
                end
            end
            bus.c_ready = bus.c_req;
            bus.c_rdata = 32'h600D0000 + n_done;
            guard++;
            tick();
        end
        if (n_done < 6) begin
            checks++;
            errors++;
            $display("[TB] FAIL fair count: got %0d completions, expected 6", n_done);
        end
        bus.c_ready = 1'b0;
`ifdef CACHE_ARB_STATS_EN
        checkOutput("fair p0_gnt_cnt", p0_gnt_cnt, 16'd3);
        checkOutput("fair p1_gnt_cnt", p1_gnt_cnt, 16'd3);
`endif

        // Operand stability, plus req dropped while BUSY.
        bus.p1_req = 1'b1; bus.p1_rw = 1'b0; bus.p1_addr = 32'h80010000; bus.p1_wdata = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("stab c_req %0d", k), bus.c_req, 1'b1);
            checkOutput($sformatf("stab c_addr %0d", k), bus.c_addr, 32'h80010000);
            if (k == 0) bus.p1_addr = 32'h80018000;
            if (k == 1) bus.p1_req = 1'b0;
            bus.c_ready = (k == 3);
            bus.c_rdata = 32'h0F0F0F0F;
            tick();
        end
        bus.c_ready = 1'b0;
        checkOutput("stab p1_done", bus.p1_done, 1'b1);
        checkOutput("stab p0_done", bus.p0_done, 1'b0);
        checkOutput("stab p1_rdata", bus.p1_rdata, 32'h0F0F0F0F);
        tick();

        // Reset in the second BUSY cycle abandons the access.
        bus.p0_req = 1'b1; bus.p0_rw = 1'b0; bus.p0_addr = 32'h80020000;
        tick();
        checkOutput("mid c_req busy1", bus.c_req, 1'b1);
        tick();
        checkOutput("mid c_req busy2", bus.c_req, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("mid c_req async", bus.c_req, 1'b0);
        checkOutput("mid p0_done", bus.p0_done, 1'b0);
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b1; bus.p1_rw = 1'b0; bus.p1_addr = 32'h80030000;
        tick();
        checkOutput("mid c_req held", bus.c_req, 1'b0);
        checkOutput("mid p0_done held", bus.p0_done, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("mid p1 granted", bus.c_req, 1'b1);
        serveOne("mid p1", 1, 1'b0, 32'h80030000, 32'h0, 0, 32'h31415926, 32'h31415926, 1'b0);

        // Randomised traffic against a cycle-level reference model.
        doReset();
        m_busy = -1; m_resp = -1; m_last = 1; m_cnt = 0;
        m_rdata = '0; m_err = 1'b0;
        op_addr = '0; op_wdata = '0; op_rw = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            q_rw[p] = 1'b0; q_addr[p] = '0; q_wdata[p] = '0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            checkOutput("rnd c_req", bus.c_req, m_busy >= 0);
            checkOutput("rnd p0_done", bus.p0_done, m_resp == 0);
            checkOutput("rnd p1_done", bus.p1_done, m_resp == 1);
            if (m_busy >= 0) begin
                checkOutput("rnd c_addr", bus.c_addr, op_addr);
                checkOutput("rnd c_rw", bus.c_rw, op_rw);
                checkOutput("rnd c_wdata", bus.c_wdata, op_wdata);
            end
            if (m_resp >= 0) begin
                checkOutput("rnd rdata", m_resp ? bus.p1_rdata : bus.p0_rdata, m_rdata);
                checkOutput("rnd err", m_resp ? bus.p1_err : bus.p0_err, m_err);
                pend[m_resp] = 1'b0;
            end

            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 99) < 40)) begin
                    pend[p]    = 1'b1;
                    q_rw[p]    = 1'($urandom_range(0, 1));
                    q_addr[p]  = $urandom;
                    q_wdata[p] = $urandom;
                end
            end
            bus.p0_req = pend[0]; bus.p0_rw = q_rw[0]; bus.p0_addr = q_addr[0]; bus.p0_wdata = q_wdata[0];
            bus.p1_req = pend[1]; bus.p1_rw = q_rw[1]; bus.p1_addr = q_addr[1]; bus.p1_wdata = q_wdata[1];

            rdy = ($urandom_range(0, 3) == 0);
            rd  = $urandom;
            bus.c_ready = rdy;
            bus.c_rdata = rd;

            n_busy = m_busy;
            n_resp = -1;
            if (m_busy >= 0) begin
                m_cnt++;
                if (rdy) begin
                    n_resp = m_busy; m_rdata = rd; m_err = 1'b0; m_last = m_busy; n_busy = -1;
                end else if (m_cnt == TMO) begin
                    n_resp = m_busy; m_rdata = '0; m_err = 1'b1; m_last = m_busy; n_busy = -1;
                end
            end else if (m_resp < 0) begin
                if (pend[0] || pend[1]) begin
                    win      = (pend[0] && pend[1]) ? (1 - m_last) : (pend[1] ? 1 : 0);
                    n_busy   = win;
                    m_cnt    = 0;
                    op_addr  = q_addr[win];
                    op_wdata = q_wdata[win];
                    op_rw    = q_rw[win];
                end
            end
            m_busy = n_busy;
            m_resp = n_resp;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single-ported cache_controller between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Round-robin arbitration with a one-outstanding-access policy.
- Latches the winner's operands, drives the cache request, waits for the cache ready, then returns read data and a one-cycle done pulse to the winner.
- A timeout guards against a hung cache.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 64, maximum BUSY cycles before the access is aborted with error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; held with operands stable until p0_done.
- p0_rw  in  1  port 0 operation: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_done  out  1  one-cycle completion pulse for port 0.
- p0_rdata  out  DATA_W  port 0 read data; valid while p0_done is high.
- p0_err  out  1  timeout flag; valid while p0_done is high.
- p1_req, p1_rw, p1_addr, p1_wdata, p1_done, p1_rdata, p1_err: same as port 0, for port 1.
- c_req  out  1  cache access in progress.
- c_rw  out  1  to cache rw.
- c_addr  out  ADDR_W  to cache address.
- c_wdata  out  DATA_W  to cache data_in.
- c_rdata  in  DATA_W  from cache data_out.
- c_ready  in  1  from cache ready.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, and all outputs 0: c_req, c_rw, c_addr, c_wdata, pN_done, pN_rdata, pN_err. last_gnt = 1, so port 0 wins the first tie. Timeout counter = 0. Reset mid-access abandons the access: no done pulse is generated and c_req drops immediately.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE, no req: stay in IDLE.
- IDLE, exactly one req: grant that port.
- IDLE, both req: grant the port that is NOT last_gnt.
- On grant, at the clock edge: latch rw/addr/wdata into c_rw/c_addr/c_wdata, set gnt_id, set c_req = 1, clear the timeout counter, go to BUSY.
- BUSY: c_req held at 1; cache operands are stable (from registers, not requester inputs).
- BUSY, c_ready = 1 at the edge: capture c_rdata into the granted pN_rdata, pN_err = 0, c_req = 0, last_gnt = gnt_id, go to RESP.
- BUSY, c_ready = 0 at the edge: increment the timeout counter. If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC-1: pN_rdata = 0, pN_err = 1, c_req = 0, last_gnt = gnt_id, go to RESP.
- RESP: exactly one cycle. Granted pN_done = 1, the other port's done = 0. Go to IDLE. pN_rdata and pN_err hold until the next completion to that port.
- Requester rule: update or drop req on the edge ending its done cycle. IDLE samples req one cycle later, so a completed request is never re-issued.
- Latency and throughput:
  - req high in an IDLE cycle t → c_req high from t+1.
  - Cache ready in cycle t+1 → done in t+2.
  - Minimum request-to-done is 2 cycles; peak rate is 1 access per 3 cycles.
- Write accesses: pN_rdata is loaded with c_rdata anyway (don't-care content); requesters ignore it.
- Req dropping while in BUSY: the access still completes and done is still pulsed.
- c_ready while IDLE/RESP: ignored.
- Both done outputs are never high in the same cycle.

Optional Feature:
- Macro CACHE_ARB_STATS_EN.
- When defined, adds outputs p0_gnt_cnt[15:0], p1_gnt_cnt[15:0] and stall_cnt[15:0]:
  - pN_gnt_cnt increments on each grant to that port.
  - stall_cnt increments each cycle a port has req high in IDLE/BUSY/RESP but is not the active grant.
  - All counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and their logic are absent; the core behaviour is identical.

Test Plan:
- Single read: p0 read 0x80000000, cache ready 1 cycle after c_req with c_rdata = 0x12345678 → c_addr = 0x80000000, c_rw = 0, p0_done pulses 2 cycles after req sampled, p0_rdata = 0x12345678, p0_err = 0.
- Simultaneous requests after reset: p0 write 0x80000004 = 0xAABBCCDD and p1 read 0x80008000 → port 0 served first with c_wdata = 0xAABBCCDD, then port 1. Done pulses never overlap.
- Fairness: both ports hold req continuously for 6 accesses → grants alternate 0,1,0,1,0,1. With CACHE_ARB_STATS_EN, p0_gnt_cnt = p1_gnt_cnt = 3.
- Timeout: TIMEOUT_CYC = 8, c_ready tied low → after 8 BUSY cycles the granted done pulses with err = 1 and rdata = 0. The next request is then accepted normally.
- Operand stability: p1 changes p1_addr from 0x80010000 to 0x80018000 while in BUSY → c_addr stays 0x80010000 until done.
- Reset mid-access: rst low in the 2nd BUSY cycle → c_req = 0 immediately, no done pulse. After release, a pending p1-only request is granted within 1 cycle.
